// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V main controller:
// opcodes, FSM states, datapath mux selects and ALU control codes.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LUI, S_HALT
  } state_t;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode from the FSM's ALU op class and the
// instruction funct fields.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_func3,
  input  logic       i_func7b5,
  input  logic       i_op5,
  output logic [2:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB:   o_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_func3)
          // op5 separates R-type from I-type: addi never subtracts.
          3'b000:  o_alu_ctrl = (i_op5 && i_func7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_ctrl = ALU_AND;
          3'b110:  o_alu_ctrl = ALU_OR;
          3'b010:  o_alu_ctrl = ALU_SLT;
          default: o_alu_ctrl = ALU_ADD;
        endcase
      end
      default:     o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_main_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences each instruction
// and drives the datapath enables and mux selects.
module mc_main_controller
  import mc_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7b5,
  input  logic       zero,
  input  logic       lt,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       halted
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_alu_op;
  logic       w_taken;
  logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write, w_done, w_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = ~lt;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_B:    imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      OP_LUI:  imm_src = IMM_U;
      default: imm_src = IMM_I;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    w_pc_write  = 1'b0;
    adr_src     = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_REG;
    w_alu_op    = ALUOP_ADD;
    w_reg_write = 1'b0;
    w_done      = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        w_pc_write = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_B:         w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          OP_LUI:       w_next = S_LUI;
          default: begin
            if (ILLEGAL_HALT) begin
              w_next = S_HALT;
            end else begin
              w_next = S_FETCH;
              w_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_MEM;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_REG;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        w_alu_op  = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = w_taken;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      // JAL and JALR_PC both redirect the PC and leave OldPc+4 in ALUOut for rd.
      S_JAL, S_JALR_PC: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
        w_next    = S_JALR_PC;
      end
      S_LUI: begin
        result_src  = RES_IMM;
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
        w_next   = S_HALT;
      end
      default: w_next = S_FETCH;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .i_alu_op   (w_alu_op),
    .i_func3    (func3),
    .i_func7b5  (func7b5),
    .i_op5      (opcode[5]),
    .o_alu_ctrl (alu_ctrl)
  );

  // The state already sits at FETCH during reset; only the enables need masking.
  assign pc_write   = w_pc_write  & ~rst;
  assign mem_write  = w_mem_write & ~rst;
  assign ir_write   = w_ir_write  & ~rst;
  assign reg_write  = w_reg_write & ~rst;
  assign instr_done = w_done      & ~rst;
  assign halted     = w_halted    & ~rst;

endmodule

// File: tb/tb_mc_main_controller.sv
// Scoreboard bench for mc_main_controller: two instances (NOP and HALT on
// illegal opcodes) share stimulus; per-cycle expected output bundles are queued.
module tb_mc_main_controller;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [2:0] IM_I = 3'b000, IM_S = 3'b001, IM_B = 3'b010, IM_J = 3'b011, IM_U = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0000000;
  logic [2:0] func3 = 3'b000;
  logic       func7b5 = 1'b0, zero = 1'b0, lt = 1'b0;

  logic       pcw0, adr0, mw0, irw0, rw0, dn0, hl0;
  logic [1:0] rs0, sa0, sb0;
  logic [2:0] alu0, imm0;
  logic       pcw1, adr1, mw1, irw1, rw1, dn1, hl1;
  logic [1:0] rs1, sa1, sb1;
  logic [2:0] alu1, imm1;

  mc_main_controller #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b5(func7b5), .zero(zero), .lt(lt),
    .pc_write(pcw0), .adr_src(adr0), .mem_write(mw0), .ir_write(irw0), .result_src(rs0),
    .alu_src_a(sa0), .alu_src_b(sb0), .alu_ctrl(alu0), .imm_src(imm0), .reg_write(rw0),
    .instr_done(dn0), .halted(hl0));

  mc_main_controller #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7b5(func7b5), .zero(zero), .lt(lt),
    .pc_write(pcw1), .adr_src(adr1), .mem_write(mw1), .ir_write(irw1), .result_src(rs1),
    .alu_src_a(sa1), .alu_src_b(sb1), .alu_ctrl(alu1), .imm_src(imm1), .reg_write(rw1),
    .instr_done(dn1), .halted(hl1));

  logic [18:0] got0, got1;
  assign got0 = {pcw0, adr0, mw0, irw0, rs0, sa0, sb0, alu0, imm0, rw0, dn0, hl0};
  assign got1 = {pcw1, adr1, mw1, irw1, rs1, sa1, sb1, alu1, imm1, rw1, dn1, hl1};

  typedef struct {
    logic [18:0] e0;
    logic [18:0] e1;
    string       nm;
  } rec_t;

  rec_t sb_q[$];
  rec_t mon_r;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Bundle order: pc_write adr_src mem_write ir_write result_src a b alu_ctrl imm_src reg_write done halted
  function automatic logic [18:0] ob(input logic pcw, adr, mw, irw, input logic [1:0] rs, sa, sb,
                                     input logic [2:0] alu, imm, input logic rw, dn, hl);
    return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, hl};
  endfunction

  function automatic logic [18:0] e_rst(input logic [2:0] imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_fetch(input logic [2:0] imm);
    return ob(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_decode(input logic [2:0] imm, input logic dn);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, dn, 1'b0);
  endfunction
  function automatic logic [18:0] e_regimm(input logic [2:0] alu, imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_execr(input logic [2:0] alu, imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_memread(input logic [2:0] imm);
    return ob(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_memwb(input logic [2:0] imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [18:0] e_memwrite(input logic [2:0] imm);
    return ob(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [18:0] e_aluwb(input logic [2:0] imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [18:0] e_branch(input logic tk, input logic [2:0] imm);
    return ob(tk, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [18:0] e_jump(input logic [2:0] imm);
    return ob(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [18:0] e_lui();
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic logic [18:0] e_halt(input logic [2:0] imm);
    return ob(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic push(input logic [18:0] e0, input logic [18:0] e1, input string nm);
    rec_t r;
    r.e0 = e0; r.e1 = e1; r.nm = nm;
    sb_q.push_back(r);
  endtask

  // Called at posedge+1: queue the expectation for this cycle, move to the next one.
  task automatic step(input logic [18:0] e0, input logic [18:0] e1, input string nm);
    push(e0, e1, nm);
    @(posedge clk);
    #1;
  endtask

  task automatic stepb(input logic [18:0] e, input string nm);
    step(e, e, nm);
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic f7, z, l);
    opcode = opc; func3 = f3; func7b5 = f7; zero = z; lt = l;
  endtask

  task automatic run_r(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string nm);
    set_in(OP_R, f3, f7, 1'b0, 1'b0);
    stepb(e_fetch(IM_I), {nm, "_fetch"});
    stepb(e_decode(IM_I, 1'b0), {nm, "_decode"});
    stepb(e_execr(alu, IM_I), {nm, "_execr"});
    stepb(e_aluwb(IM_I), {nm, "_aluwb"});
  endtask

  task automatic run_i(input logic [2:0] f3, input logic f7, input logic [2:0] alu, input string nm);
    set_in(OP_I, f3, f7, 1'b0, 1'b0);
    stepb(e_fetch(IM_I), {nm, "_fetch"});
    stepb(e_decode(IM_I, 1'b0), {nm, "_decode"});
    stepb(e_regimm(alu, IM_I), {nm, "_execi"});
    stepb(e_aluwb(IM_I), {nm, "_aluwb"});
  endtask

  task automatic run_br(input logic [2:0] f3, input logic z, l, tk, input string nm);
    set_in(OP_B, f3, 1'b0, z, l);
    stepb(e_fetch(IM_B), {nm, "_fetch"});
    stepb(e_decode(IM_B, 1'b0), {nm, "_decode"});
    stepb(e_branch(tk, IM_B), {nm, "_branch"});
  endtask

  task automatic run_lui(input string nm);
    set_in(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_U), {nm, "_fetch"});
    stepb(e_decode(IM_U, 1'b0), {nm, "_decode"});
    stepb(e_lui(), {nm, "_lui"});
  endtask

  // Monitor: compares both instances on every negedge, and right after an async reset edge.
  always begin
    @(negedge clk or posedge rst);
    #1;
    if (sb_q.size() > 0) begin
      mon_r = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (got0 !== mon_r.e0) begin
        n_bad = n_bad + 1;
        $display("FAIL %s nop_inst: got %b expected %b", mon_r.nm, got0, mon_r.e0);
      end
      n_cmp = n_cmp + 1;
      if (got1 !== mon_r.e1) begin
        n_bad = n_bad + 1;
        $display("FAIL %s halt_inst: got %b expected %b", mon_r.nm, got1, mon_r.e1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    stepb(e_rst(IM_I), "reset");
    rst = 1'b0;

    run_r(3'b000, 1'b0, 3'b000, "add");
    run_r(3'b000, 1'b1, 3'b001, "sub");
    run_r(3'b010, 1'b0, 3'b101, "slt");
    run_r(3'b110, 1'b0, 3'b011, "or");
    run_i(3'b000, 1'b1, 3'b000, "addi_f7");
    run_i(3'b111, 1'b0, 3'b010, "andi");

    set_in(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_I), "lw_fetch");
    stepb(e_decode(IM_I, 1'b0), "lw_decode");
    stepb(e_regimm(3'b000, IM_I), "lw_memadr");
    stepb(e_memread(IM_I), "lw_memread");
    stepb(e_memwb(IM_I), "lw_memwb");

    set_in(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_S), "sw_fetch");
    stepb(e_decode(IM_S, 1'b0), "sw_decode");
    stepb(e_regimm(3'b000, IM_S), "sw_memadr");
    stepb(e_memwrite(IM_S), "sw_memwrite");

    run_br(3'b000, 1'b1, 1'b0, 1'b1, "beq_taken");
    run_br(3'b000, 1'b0, 1'b0, 1'b0, "beq_not");
    run_br(3'b001, 1'b0, 1'b0, 1'b1, "bne_taken");
    run_br(3'b100, 1'b0, 1'b1, 1'b1, "blt_taken");
    run_br(3'b101, 1'b0, 1'b1, 1'b0, "bge_not");
    run_br(3'b010, 1'b1, 1'b1, 1'b0, "b_f3_010");

    set_in(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_J), "jal_fetch");
    stepb(e_decode(IM_J, 1'b0), "jal_decode");
    stepb(e_jump(IM_J), "jal_jal");
    stepb(e_aluwb(IM_J), "jal_aluwb");

    set_in(OP_JALR, 3'b000, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_I), "jalr_fetch");
    stepb(e_decode(IM_I, 1'b0), "jalr_decode");
    stepb(e_regimm(3'b000, IM_I), "jalr_jalr");
    stepb(e_jump(IM_I), "jalr_pc");
    stepb(e_aluwb(IM_I), "jalr_aluwb");

    run_lui("lui");

    // Reset pulse in the middle of a MEMREAD cycle, between clock edges.
    set_in(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
    stepb(e_fetch(IM_I), "lwr_fetch");
    stepb(e_decode(IM_I, 1'b0), "lwr_decode");
    stepb(e_regimm(3'b000, IM_I), "lwr_memadr");
    push(e_memread(IM_I), e_memread(IM_I), "lwr_memread");
    @(negedge clk);
    #3;
    push(e_rst(IM_I), e_rst(IM_I), "async_rst");
    rst = 1'b1;
    @(posedge clk);
    #1;
    stepb(e_rst(IM_I), "rst_hold");
    rst = 1'b0;
    run_lui("post_rst_lui");

    // Unknown opcode: NOP instance returns to FETCH, HALT instance sticks.
    set_in(7'h7F, 3'b000, 1'b0, 1'b0, 1'b0);
    step(e_fetch(IM_I), e_fetch(IM_I), "ill_fetch");
    step(e_decode(IM_I, 1'b1), e_decode(IM_I, 1'b0), "ill_decode");
    set_in(OP_LUI, 3'b000, 1'b0, 1'b0, 1'b0);
    step(e_fetch(IM_U), e_halt(IM_U), "halt1");
    step(e_decode(IM_U, 1'b0), e_halt(IM_U), "halt2");
    step(e_lui(), e_halt(IM_U), "halt3");
    rst = 1'b1;
    step(e_rst(IM_U), e_rst(IM_U), "halt_rst");
    rst = 1'b0;
    run_i(3'b110, 1'b0, 3'b011, "ori_after_halt");

    @(negedge clk);
    #3;
    if (sb_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
